// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser
// Description : Byte-level command decoder between the UART receiver and the
//               game controller. Assembles short ASCII frames into MOVE
//               ('1'..'9' + CR/LF) and NEW_GAME ('R'/'r' + CR/LF) commands,
//               offered on a valid/ready handshake. Every byte the parser
//               accepts is also queued in a small echo FIFO for the UART
//               transmitter.
// Ports       : clk        - system clock, rising edge
//               reset_n    - asynchronous active-low reset
//               rx_data    - received byte, sampled when rx_valid=1
//               rx_valid   - one-cycle strobe per received byte
//               cmd_valid  - command pending
//               cmd_ready  - controller accepts the pending command
//               cmd_type   - 01 MOVE, 10 NEW_GAME, 00 idle
//               cmd_cell   - board cell 0..8 for MOVE, 0 otherwise
//               err        - one-cycle pulse on a malformed frame
//               ovr        - one-cycle pulse when a byte is dropped
//               echo_data  - echo FIFO head byte
//               echo_valid - echo FIFO not empty
//               echo_ready - transmitter pops the head
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
    parameter int FIFO_DEPTH = 4,
    parameter int ECHO_EN    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_type,
    output logic [3:0] cmd_cell,
    output logic       err,
    output logic       ovr,
    output logic [7:0] echo_data,
    output logic       echo_valid,
    input  logic       echo_ready
);

    localparam int         c_AW      = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};
    localparam bit         c_ECHO_ON = (ECHO_EN != 0);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_GOT_MOVE = 2'd1;
    localparam logic [1:0] c_ST_GOT_NEW  = 2'd2;
    localparam logic [1:0] c_ST_HOLD     = 2'd3;

    localparam logic [1:0] c_TYPE_MOVE = 2'b01;
    localparam logic [1:0] c_TYPE_NEW  = 2'b10;

    // ------------------------------------------------------------------
    // Character classification
    // ------------------------------------------------------------------
    logic w_is_digit;
    logic w_is_new;
    logic w_is_term;

    assign w_is_digit = (rx_data >= 8'h31) && (rx_data <= 8'h39);
    assign w_is_new   = (rx_data == 8'h52) || (rx_data == 8'h72);
    assign w_is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);

    // ------------------------------------------------------------------
    // Parser FSM
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [3:0] r_cell;
    logic [3:0] w_cell_next;
    logic       w_load_cmd;
    logic       w_clear_cmd;
    logic       w_err;
    logic       w_in_hold;

    assign w_in_hold = (r_state == c_ST_HOLD);

    always_comb begin
        w_next_state = r_state;
        w_cell_next  = r_cell;
        w_load_cmd   = 1'b0;
        w_clear_cmd  = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (rx_valid) begin
                    if (w_is_digit) begin
                        // Low nibble of '1'..'9' is 1..9, so minus one gives the cell.
                        w_cell_next  = rx_data[3:0] - 4'd1;
                        w_next_state = c_ST_GOT_MOVE;
                    end else if (w_is_new) begin
                        w_next_state = c_ST_GOT_NEW;
                    end else if (!w_is_term) begin
                        w_err = 1'b1;
                    end
                end
            end
            c_ST_GOT_MOVE,
            c_ST_GOT_NEW: begin
                if (rx_valid) begin
                    if (w_is_term) begin
                        w_load_cmd   = 1'b1;
                        w_next_state = c_ST_HOLD;
                    end else begin
                        w_err        = 1'b1;
                        w_next_state = c_ST_IDLE;
                    end
                end
            end
            default: begin
                if (cmd_ready) begin
                    w_clear_cmd  = 1'b1;
                    w_next_state = c_ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_ST_IDLE;
            r_cell    <= 4'd0;
            cmd_valid <= 1'b0;
            cmd_type  <= 2'b00;
            cmd_cell  <= 4'd0;
            err       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cell  <= w_cell_next;
            err     <= w_err;
            if (w_load_cmd) begin
                cmd_valid <= 1'b1;
                if (r_state == c_ST_GOT_MOVE) begin
                    cmd_type <= c_TYPE_MOVE;
                    cmd_cell <= r_cell;
                end else begin
                    cmd_type <= c_TYPE_NEW;
                    cmd_cell <= 4'd0;
                end
            end else if (w_clear_cmd) begin
                cmd_valid <= 1'b0;
                cmd_type  <= 2'b00;
                cmd_cell  <= 4'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Echo FIFO: extra pointer bit distinguishes full from empty.
    // ------------------------------------------------------------------
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push_req;
    logic        w_push;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop      = !w_empty && echo_ready;
    assign w_push_req = c_ECHO_ON && rx_valid && !w_in_hold;
    // A same-edge pop frees the slot the push lands in.
    assign w_push     = w_push_req && (!w_full || w_pop);

    assign echo_valid = !w_empty;
    assign echo_data  = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= rx_data;
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Dropped byte: strobed during HOLD, or echo FIFO full with no pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr <= 1'b0;
        end else begin
            ovr <= (rx_valid && w_in_hold) || (w_push_req && w_full && !w_pop);
        end
    end

endmodule
`default_nettype wire
